adder_seq_ctrl: RTL
===================

ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
- REQ-001: Parameter NBYTES, default 4: operand width in bytes, legal range 1..16. W = 8*NBYTES.
- REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-003: rst  input  1  synchronous, active-high reset.
- REQ-004: in_valid  input  1  operand request valid.
- REQ-005: in_ready  output  1  block can accept an operand request.
- REQ-006: a  input  W  operand A.
- REQ-007: b  input  W  operand B.
- REQ-008: cin  input  1  carry-in to byte 0.
- REQ-009: out_valid  output  1  result valid.
- REQ-010: out_ready  input  1  consumer accepts the result.
- REQ-011: sum  output  W  registered result.
- REQ-012: cout  output  1  carry-out of the most significant byte.
- REQ-013: busy  output  1  high whenever the state is not IDLE.
- REQ-014: ovf  output  1  signed overflow; the port SHALL exist only when ADDER_SEQ_OVF_EN is defined.

Function
- REQ-015: The block SHALL contain exactly one 8-bit add stage, {c,s} = a_byte + b_byte + carry_reg, reused once per byte, LSB byte first.
- REQ-016: States SHALL be IDLE, RUN and DONE, with no other reachable state.
- REQ-017: in_ready SHALL equal (state==IDLE) && !rst.
- REQ-018: Accept condition: in_valid && in_ready at an edge latches a, b and cin, clears byte index idx to 0, and moves IDLE to RUN.
- REQ-019: Operand inputs SHALL be ignored while not in IDLE; the latched copies alone drive computation.
- REQ-020: Each RUN edge SHALL:
  - write s into sum byte idx;
  - load c into carry_reg;
  - increment idx.
- REQ-021: The RUN edge with idx==NBYTES-1 SHALL move to DONE and load cout with c.
- REQ-022: Latency: out_valid SHALL rise exactly NBYTES edges after the accepting edge; this gives 4 cycles at the default NBYTES.
- REQ-023: out_valid SHALL equal (state==DONE).
- REQ-024: sum, cout and ovf SHALL be held stable from DONE entry until the next accept.
- REQ-025: DONE with out_ready high SHALL move to IDLE at the next edge.
- REQ-026: There SHALL be no accept in the same cycle as the result handoff; in_ready rises the cycle after the handoff.
- REQ-027: DONE with out_ready low SHALL hold indefinitely (backpressure).
- REQ-028: Sum bytes not yet written in the current operation SHALL retain their previous values.
- REQ-029: Carry chaining SHALL be exact: the result equals (a + b + cin) mod 2^W, and cout equals bit W of the full sum.
- REQ-030: idx SHALL never exceed NBYTES-1.

Reset
- REQ-031: While rst is high at an edge, the block SHALL set:
  - state = IDLE;
  - idx = 0;
  - carry_reg = 0;
  - sum = 0;
  - cout = 0;
  - ovf = 0;
  - out_valid = 0;
  - busy = 0.
- REQ-032: rst SHALL take priority over every other input at the same edge.
- REQ-033: Reset during RUN or DONE SHALL abort the operation; out_valid SHALL NOT assert for the aborted request.
- REQ-034: The first accept SHALL be possible on the first edge after rst deasserts.

Configuration
- REQ-035: With ADDER_SEQ_OVF_EN defined, ovf SHALL be loaded on the final RUN edge with (carry into bit W-1) XOR (carry out of bit W-1).
- REQ-036: Without ADDER_SEQ_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NBYTES=4 unless stated)
- REQ-037: a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, out_valid 4 edges after accept.
- REQ-038: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
- REQ-039: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1 (macro defined).
- REQ-040: Backpressure: out_ready held low 5 cycles in DONE with in_valid high and new operands -> sum/cout stable, in_ready=0, no second accept; accept occurs 1 cycle after handoff.
- REQ-041: rst pulsed at the 2nd RUN edge -> next cycle state IDLE, sum=0, out_valid=0; the following request a=0x12345678, b=0x11111111 -> sum=0x23456789.
- REQ-042: NBYTES=1: a=0x80, b=0x80, cin=0 -> sum=0x00, cout=1, ovf=1, out_valid 1 edge after accept.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Byte-serial adder: one 8-bit add stage reused LSB byte first, with valid/ready handshakes.
// Optional signed-overflow output is enabled by defining ADDER_SEQ_OVF_EN.
module adder_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  busy
`ifdef ADDER_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [NBYTES-1:0][7:0] a;
    logic [NBYTES-1:0][7:0] b;
  } req_t;

  state_t                 state_q, state_d;
  req_t                   req_q, req_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [NBYTES-1:0][7:0] sum_q, sum_d;
  logic                   cout_q, cout_d;
`ifdef ADDER_SEQ_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  logic       accept;
  logic       last;
  logic [7:0] a_byte, b_byte, s_add;
  logic       c_add;

  assign accept = in_valid && in_ready;
  assign last   = (idx_q == IDXW'(NBYTES - 1));

  // The single shared byte adder; operands come only from the latched request.
  always_comb begin
    a_byte         = req_q.a[idx_q];
    b_byte         = req_q.b[idx_q];
    {c_add, s_add} = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_q};
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_RUN;
      S_RUN:   if (last)      state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !rst;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  // Datapath next-state
  always_comb begin
    req_d   = req_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADDER_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      req_d.a = a;
      req_d.b = b;
      carry_d = cin;
      idx_d   = '0;
    end
    if (state_q == S_RUN) begin
      sum_d[idx_q] = s_add;
      carry_d      = c_add;
      if (last) begin
        idx_d  = '0;
        cout_d = c_add;
`ifdef ADDER_SEQ_OVF_EN
        // Carry into the sign bit is recovered from the sign-bit sum.
        ovf_d  = (a_byte[7] ^ b_byte[7] ^ s_add[7]) ^ c_add;
`endif
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      req_q   <= req_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADDER_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef ADDER_SEQ_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
